// File: rtl/queue_sender_if.sv
// ----------------------------------------------------------------------------
// queue_sender_if
// Bundles the signals between the queue sender, its input queue, the output
// arbiter and the downstream link.
//   q_empty / q_data / q_readed : queue status, async head flit, pop strobe
//   req / gnt                   : output-channel arbitration
//   tx_data / tx_valid /
//   tx_ready / tx_last          : flit stream towards the downstream link
//   busy / pkt_cnt              : status (sender not idle, packets sent)
// master = the sender, slave = the environment (queue, arbiter, link).
// ----------------------------------------------------------------------------
interface queue_sender_if #(
    parameter int BUS_SIZE = 32,
    parameter int CNT_SIZE = 16
);
    logic                q_empty;
    logic [BUS_SIZE-1:0] q_data;
    logic                q_readed;
    logic                req;
    logic                gnt;
    logic [BUS_SIZE-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic                tx_last;
    logic                busy;
    logic [CNT_SIZE-1:0] pkt_cnt;

    modport master (
        input  q_empty, q_data, gnt, tx_ready,
        output q_readed, req, tx_data, tx_valid, tx_last, busy, pkt_cnt
    );

    modport slave (
        output q_empty, q_data, gnt, tx_ready,
        input  q_readed, req, tx_data, tx_valid, tx_last, busy, pkt_cnt
    );
endinterface

// File: rtl/queue_sender.sv
// ----------------------------------------------------------------------------
// queue_sender
// Read side of a switch input queue. Takes whole packets (one header flit
// whose low LEN_SIZE bits hold the payload length N, then N payload flits)
// from the queue head, requests the output arbiter once per packet and, once
// granted, streams every flit of the packet to the output channel.
// Ports:
//   clk   : clock, rising edge
//   a_rst : synchronous active-high reset
//   bus   : queue_sender_if.master (queue, arbiter, tx link, status)
// ----------------------------------------------------------------------------
module queue_sender #(
    parameter int BUS_SIZE = 32,
    parameter int LEN_SIZE = 8,
    parameter int CNT_SIZE = 16
) (
    input  logic           clk,
    input  logic           a_rst,
    queue_sender_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    localparam logic [LEN_SIZE:0]   REM_ONE = {{LEN_SIZE{1'b0}}, 1'b1};
    localparam logic [CNT_SIZE-1:0] CNT_ONE = {{(CNT_SIZE-1){1'b0}}, 1'b1};

    logic [1:0]          state_q, state_d;
    // Flits still to send, header included; one extra bit so that a maximum
    // length packet (N = 2**LEN_SIZE-1) loads 2**LEN_SIZE without overflow.
    logic [LEN_SIZE:0]   rem_q, rem_d;
    logic [CNT_SIZE-1:0] pkt_cnt_q, pkt_cnt_d;

    logic                sending;
    logic                tx_valid_c;
    logic                handshake;
    logic [BUS_SIZE-1:0] tx_data_c;

    // The head flit is offered straight from the async queue read port; a pop
    // happens only on a handshake, so a stalled flit stays stable by itself.
    always_comb begin
        sending    = (state_q == S_SEND);
        tx_valid_c = sending & ~bus.q_empty;
        handshake  = tx_valid_c & bus.tx_ready;
        tx_data_c  = tx_valid_c ? bus.q_data : '0;
    end

    assign bus.req      = (state_q == S_REQ) | sending;
    assign bus.tx_valid = tx_valid_c;
    assign bus.tx_data  = tx_data_c;
    assign bus.tx_last  = tx_valid_c & (rem_q == REM_ONE);
    assign bus.q_readed = handshake;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.pkt_cnt  = pkt_cnt_q;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        pkt_cnt_d = pkt_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.q_empty) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Header sits at the queue head; read its length without popping.
                if (bus.gnt) begin
                    rem_d   = {1'b0, bus.q_data[LEN_SIZE-1:0]} + REM_ONE;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // gnt is not looked at here: the channel is held until the
                // last flit is accepted.
                if (handshake) begin
                    rem_d = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        pkt_cnt_d = pkt_cnt_q + CNT_ONE;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (a_rst) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end
endmodule

// File: tb/tb_queue_sender.sv
// ----------------------------------------------------------------------------
// tb_queue_sender
// Bench for queue_sender. The bench plays the input queue (a flit FIFO with an
// async head), the arbiter and the downstream link. Every flit pushed into the
// queue carries a flag telling whether it ends its packet, so the expected
// tx stream, tx_last and packet count follow directly from the packet list.
// ----------------------------------------------------------------------------
module tb_queue_sender;
    localparam int BUS_SIZE = 32;
    localparam int LEN_SIZE = 8;
    localparam int CNT_SIZE = 16;

    logic clk = 1'b0;
    logic a_rst;

    always #5 clk = ~clk;

    queue_sender_if #(.BUS_SIZE(BUS_SIZE), .CNT_SIZE(CNT_SIZE)) bus ();

    queue_sender #(
        .BUS_SIZE(BUS_SIZE),
        .LEN_SIZE(LEN_SIZE),
        .CNT_SIZE(CNT_SIZE)
    ) dut (
        .clk  (clk),
        .a_rst(a_rst),
        .bus  (bus)
    );

    // Queue model: flits visible to the sender, plus flits staged for later.
    logic [BUS_SIZE-1:0] qmem[$];
    bit                  qlast[$];
    logic [BUS_SIZE-1:0] stage[$];
    bit                  stage_last[$];

    int                  tests = 0;
    int                  failed = 0;
    logic [CNT_SIZE-1:0] exp_cnt = '0;
    bit                  granted = 1'b0;
    bit                  just_done = 1'b0;
    bit                  prev_stall = 1'b0;
    logic [BUS_SIZE-1:0] prev_data = '0;
    int                  req_wait = 0;
    int                  gnt_delay = 0;
    bit                  drop_gnt = 1'b0;
    bit                  rand_ready = 1'b0;
    bit                  ready_pat[$];
    int                  cyc = 0;
    int                  pops = 0;
    int                  first_valid = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic make_pkt(input int len);
        logic [BUS_SIZE-1:0] w;
        w = BUS_SIZE'($urandom());
        w[LEN_SIZE-1:0] = LEN_SIZE'(len);
        stage.push_back(w);
        stage_last.push_back(len == 0);
        for (int i = 1; i <= len; i++) begin
            stage.push_back(BUS_SIZE'($urandom()));
            stage_last.push_back(i == len);
        end
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            if (stage.size() > 0) begin
                qmem.push_back(stage.pop_front());
                qlast.push_back(stage_last.pop_front());
            end
        end
    endtask

    // One clock cycle: drive at negedge, check after settling, update the
    // model after the rising edge.
    task automatic cycle();
        bit rdy;
        bit empty;
        bit exp_valid;
        bit hs;
        bit gnt_now;
        @(negedge clk);
        cyc++;
        if (ready_pat.size() > 0) rdy = ready_pat.pop_front();
        else if (rand_ready) rdy = 1'($urandom_range(0, 1));
        else rdy = 1'b1;
        empty = (qmem.size() == 0);
        bus.tx_ready = rdy;
        bus.q_empty  = empty;
        bus.q_data   = empty ? BUS_SIZE'($urandom()) : qmem[0];
        gnt_now      = bus.req && !granted && (req_wait >= gnt_delay);
        bus.gnt      = gnt_now || (granted && !drop_gnt);
        #1;
        exp_valid = granted && !empty;
        chk("tx_valid", bus.tx_valid, exp_valid);
        if (exp_valid) begin
            chk("tx_data", bus.tx_data, qmem[0]);
            chk("tx_last", bus.tx_last, qlast[0]);
        end else begin
            chk("tx_data_zero", bus.tx_data, 0);
            chk("tx_last_zero", bus.tx_last, 0);
        end
        chk("q_readed", bus.q_readed, exp_valid && rdy);
        chk("pkt_cnt", bus.pkt_cnt, exp_cnt);
        if (granted || req_wait > 0) chk("req_held", bus.req, 1);
        if (granted) chk("busy_send", bus.busy, 1);
        if (just_done) begin
            chk("req_after_last", bus.req, 0);
            chk("busy_after_last", bus.busy, 0);
        end
        if (prev_stall && exp_valid) chk("stall_data", bus.tx_data, prev_data);
        if (bus.q_readed) pops++;
        if (bus.tx_valid && first_valid < 0) first_valid = cyc;
        hs         = exp_valid && rdy;
        prev_stall = exp_valid && !rdy;
        prev_data  = bus.tx_data;
        if (bus.req && !granted && !gnt_now) req_wait++;
        @(posedge clk);
        #1;
        just_done = 1'b0;
        if (gnt_now) begin
            granted  = 1'b1;
            req_wait = 0;
        end
        if (hs) begin
            if (qlast[0]) begin
                exp_cnt++;
                granted   = 1'b0;
                just_done = 1'b1;
            end
            void'(qmem.pop_front());
            void'(qlast.pop_front());
        end
    endtask

    // Run until the queue is empty and no packet is in flight, then one more
    // cycle so the fall of req after the last flit is seen.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((qmem.size() != 0 || granted) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_timeout", (qmem.size() != 0 || granted), 0);
        cycle();
    endtask

    task automatic apply_reset(input int ncyc, input bit flush);
        @(negedge clk);
        a_rst        = 1'b1;
        bus.gnt      = 1'b0;
        bus.tx_ready = 1'b1;
        bus.q_empty  = (qmem.size() == 0);
        bus.q_data   = (qmem.size() > 0) ? qmem[0] : '0;
        repeat (ncyc) @(posedge clk);
        #1;
        chk("rst_req", bus.req, 0);
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_last", bus.tx_last, 0);
        chk("rst_q_readed", bus.q_readed, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_pkt_cnt", bus.pkt_cnt, 0);
        granted    = 1'b0;
        just_done  = 1'b0;
        prev_stall = 1'b0;
        req_wait   = 0;
        exp_cnt    = '0;
        @(negedge clk);
        a_rst = 1'b0;
        if (flush) begin
            qmem.delete();
            qlast.delete();
            stage.delete();
            stage_last.delete();
        end
        bus.q_empty = (qmem.size() == 0);
    endtask

    initial begin
        int t0;
        int n;
        a_rst        = 1'b0;
        bus.q_empty  = 1'b1;
        bus.q_data   = '0;
        bus.gnt      = 1'b0;
        bus.tx_ready = 1'b1;

        // Reset with the queue empty, then stay idle.
        apply_reset(2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("idle_busy", bus.busy, 0);
            chk("idle_req", bus.req, 0);
        end

        // Single packet, len=3, grant one cycle after req.
        gnt_delay   = 1;
        pops        = 0;
        first_valid = -1;
        make_pkt(3);
        push_n(4);
        t0 = cyc;
        drain(50);
        chk("single_latency", first_valid - t0, 4);
        chk("single_pops", pops, 4);
        chk("single_cnt", bus.pkt_cnt, 1);

        // Backpressure, len=2, ready pattern 1,0,0,1,0,1.
        gnt_delay = 0;
        make_pkt(2);
        push_n(3);
        n = 0;
        while (!granted && n < 20) begin
            cycle();
            n++;
        end
        chk("bp_grant_timeout", granted, 1);
        pops = 0;
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        drain(50);
        chk("bp_pops", pops, 3);
        chk("bp_cnt", bus.pkt_cnt, 2);

        // Underrun: len=5, only header + 1 payload present, 4 empty cycles.
        make_pkt(5);
        push_n(2);
        n = 0;
        while (qmem.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        chk("underrun_timeout", qmem.size(), 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("gap_valid", bus.tx_valid, 0);
            chk("gap_req", bus.req, 1);
        end
        pops = 0;
        push_n(4);
        drain(50);
        chk("underrun_pops", pops, 4);
        chk("underrun_cnt", bus.pkt_cnt, 3);

        // Header-only packet, then maximum length packet.
        make_pkt(0);
        push_n(1);
        drain(20);
        chk("hdr_only_cnt", bus.pkt_cnt, 4);
        pops = 0;
        make_pkt(255);
        push_n(256);
        drain(600);
        chk("max_pops", pops, 256);
        chk("max_cnt", bus.pkt_cnt, 5);

        // Random back-to-back packets, random ready, gnt dropped after grant.
        rand_ready = 1'b1;
        drop_gnt   = 1'b1;
        gnt_delay  = int'($urandom_range(0, 3));
        for (int i = 0; i < 12; i++) make_pkt(int'($urandom_range(0, 12)));
        push_n(stage.size());
        drain(3000);
        chk("rand1_cnt", bus.pkt_cnt, 17);
        drop_gnt  = 1'b0;
        gnt_delay = int'($urandom_range(0, 3));
        for (int i = 0; i < 12; i++) make_pkt(int'($urandom_range(0, 12)));
        push_n(stage.size());
        drain(3000);
        chk("rand2_cnt", bus.pkt_cnt, 29);
        rand_ready = 1'b0;

        // Reset mid-packet after 2 of 6 flits.
        gnt_delay = 0;
        pops      = 0;
        make_pkt(5);
        push_n(6);
        n = 0;
        while (pops < 2 && n < 20) begin
            cycle();
            n++;
        end
        chk("midrst_timeout", pops, 2);
        apply_reset(1, 1'b1);
        cycle();
        chk("midrst_idle", bus.busy, 0);

        // Grant held off for 10 req cycles: no pops, req stays up.
        gnt_delay = 10;
        pops      = 0;
        make_pkt(1);
        push_n(2);
        for (int i = 0; i < 11; i++) cycle();
        chk("delay_pops", pops, 0);
        chk("delay_req", bus.req, 1);
        drain(50);
        chk("delay_done_pops", pops, 2);
        chk("delay_cnt", bus.pkt_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/queue_sender.md
Name: queue_sender

Overview:
- Read side of the switch input queue. Drains whole packets from the queue and forwards them flit-by-flit to an output channel.
- Connects to the queue's status (empty), async read data, and pop strobe (mem_readed).
- Requests the output arbiter once per packet. Once granted, holds the channel until the packet's last flit is accepted.
- A packet is one header flit followed by N payload flits. N is carried in the header's low LEN_SIZE bits.

Parameters:
- BUS_SIZE, 32, flit width; must equal the queue's BUS_SIZE.
- LEN_SIZE, 8, width of the header length field in header bits [LEN_SIZE-1:0]; N ranges 0..2**LEN_SIZE-1.
- CNT_SIZE, 16, width of the sent-packet counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- a_rst  in  1  synchronous, active-high reset.
- q_empty  in  1  queue empty flag.
- q_data  in  BUS_SIZE  queue head flit (async read, valid when q_empty=0).
- q_readed  out  1  pop strobe to the queue (drives mem_readed); one pulse per flit consumed.
- req  out  1  output-channel request to the arbiter.
- gnt  in  1  arbiter grant.
- tx_data  out  BUS_SIZE  flit to the downstream link.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts the flit this cycle.
- tx_last  out  1  current tx flit is the last flit of the packet.
- busy  out  1  state != IDLE.
- pkt_cnt  out  CNT_SIZE  count of fully sent packets; wraps modulo 2**CNT_SIZE.

Behaviour:
- Reset:
  - Sampled only on the clk edge while a_rst=1.
  - Sets state=IDLE, rem=0, pkt_cnt=0.
  - Result: req=0, tx_valid=0, tx_last=0, q_readed=0, busy=0, tx_data=0.
- Reset mid-packet abandons the packet. Queue contents are untouched; the queue has its own reset. No flush is performed.
- Internal counter rem is LEN_SIZE+1 bits wide and holds the flits remaining in the packet, header included.
- FSM states: IDLE, REQ, SEND.
- IDLE:
  - req=0.
  - If q_empty=0, go to REQ on the next edge.
- REQ:
  - req=1, tx_valid=0.
  - On an edge with gnt=1: load rem <= {1'b0, q_data[LEN_SIZE-1:0]} + 1, go to SEND.
  - The header is at the queue head and is not popped in REQ.
- SEND (combinational outputs):
  - req=1.
  - tx_data = q_data.
  - tx_valid = ~q_empty.
  - tx_last = tx_valid & (rem == 1).
  - q_readed = tx_valid & tx_ready.
  - tx_data = 0 when tx_valid=0.
- SEND, per handshake (tx_valid & tx_ready): rem <= rem - 1.
  - If rem==1, also: pkt_cnt <= pkt_cnt + 1 and state <= IDLE.
  - In the cycle after the last flit: req=0, q_readed=0.
- Latency:
  - Header flit appears on tx no earlier than 2 cycles after q_empty falls in IDLE (IDLE->REQ, then grant edge).
  - Subsequent flits: zero added latency, one flit per cycle while q_empty=0 and tx_ready=1.
- Queue empty mid-packet: tx_valid=0, state and rem hold, req stays 1; resume when q_empty=0.
- Valid/data stability: once tx_valid=1, tx_valid and tx_data stay stable until tx_ready=1, because nothing pops without a handshake.
- gnt is sampled only in REQ. Deassertion during SEND is ignored; the arbiter must hold the grant until req drops.
- q_readed is never 1 when q_empty=1, and never 1 outside SEND.
- Back-to-back packets: after the last flit, at least one IDLE cycle and one REQ cycle occur before the next header is sent (arbitration fairness gap).
- N=0: header-only packet; tx_last=1 on the header flit.
- N=2**LEN_SIZE-1: rem=2**LEN_SIZE, with no overflow in the LEN_SIZE+1-bit width.

Test Plan:
- Reset then idle: a_rst=1 for 2 cycles with the queue empty → req, tx_valid, q_readed, busy = 0, pkt_cnt=0; state remains IDLE with q_empty=1.
- Single packet, header len=3, gnt one cycle after req, tx_ready=1 → 4 consecutive flits on tx, exactly 4 q_readed pulses, tx_last on the 4th only, pkt_cnt=1, req falls the cycle after.
- Backpressure: len=2, tx_ready toggling 1,0,0,1,0,1 → tx_data/tx_valid held stable during tx_ready=0, q_readed only on ready cycles, 3 flits delivered in order.
- Queue underrun mid-packet: len=5, queue supplies 2 flits then empty for 4 cycles → tx_valid=0 and req=1 during the gap, rem preserved, remaining 4 flits sent after refill, pkt_cnt +1.
- Header-only and max length: len=0 → 1 flit with tx_last=1; len=255 (LEN_SIZE=8) → 256 flits, tx_last only on the 256th.
- Reset mid-packet after 2 of 6 flits, then delayed grant: at the reset edge, outputs go to zero, pkt_cnt=0, state=IDLE. Separately, with gnt held 0 for 10 cycles, req stays 1, tx_valid stays 0, and no pops occur.
